multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle RISC-V control unit: replaces single-cycle opcode decode with a state machine sequencing FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It handles ready/valid-style memory waits with optional timeout, traps on illegal opcodes, and counts retired instructions. It sits between the instruction register and the datapath enables, driving the same control signal set plus PC/IR write strobes.

## Interface
- `MEM_TIMEOUT`, default 16: maximum wait cycles for any memory ready; 0 disables the timeout.
- `ENABLE_JALR`, default 1: 1 decodes JALR (1100111); 0 treats it as illegal.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Opcode`  in  7  opcode field of the instruction register.
- `imem_ready`  in  1  instruction memory has data this cycle.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `IMemReq`, `DMemReq`  out  1  memory request strobes.
- `IRWrite`, `PCWrite`  out  1  instruction-register and PC write enables.
- `ALUSrc`, `MemtoReg`, `RegWrite`, `MemRead`, `MemWrite`, `Branch`, `JSel`, `JalrSel`  out  1  datapath controls.
- `ALUOp`  out  2  00 add (LW/SW/JAL/JALR), 01 branch, 10 R/I, 11 LUI.
- `trap`  out  1  sticky fault flag.
- `trap_cause`  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- `instret`  out  CNT_W  retired-instruction count.

## Operation
- Classes: R 0110011, I 0010011, LUI 0110111, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111 (when enabled). Any other value is illegal.
- The class is registered in DECODE and held until the next FETCH. ALUSrc, ALUOp, MemtoReg, JSel and JalrSel derive from the registered class and are valid from EXECUTE through WRITEBACK. They read 0 in FETCH, DECODE and TRAP.
- ALUSrc = LW | SW | I | LUI | JALR.
- FETCH: IMemReq=1. When imem_ready=1, IRWrite=1 (Mealy, same cycle), then go to DECODE.
- DECODE: illegal class goes to TRAP with cause 01. Otherwise go to EXECUTE.
- EXECUTE:
  - BR: Branch=1 and PCWrite=1, retire, go to FETCH. The datapath gates the branch target with Zero.
  - LW/SW: go to MEM.
  - Others: go to WRITEBACK.
- MEM: DMemReq=1, with MemRead=LW and MemWrite=SW. On dmem_ready:
  - SW: PCWrite=1, retire, go to FETCH.
  - LW: go to WRITEBACK.
- WRITEBACK: RegWrite=1, PCWrite=1, retire, go to FETCH. MemtoReg=LW, JSel=JAL, JalrSel=JALR.
- TRAP: absorbing state. All strobes and enables are 0, trap=1 and trap_cause is held. Only reset exits TRAP.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle that ready=0.
  - When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with ready still 0, go to TRAP with cause 10 (FETCH) or 11 (MEM).
  - ready=1 in the same cycle that the limit is hit wins; no trap.
  - Counter width is $clog2(MEM_TIMEOUT+1).
- instret increments by 1 on every retire pulse (coincident with PCWrite) and wraps modulo 2^CNT_W.

## Timing
- While rst_n=0: state=FETCH, class=none, wait counter=0, instret=0, trap=0, trap_cause=00, and every output is forced to 0, including IMemReq.
- The first IMemReq is asserted in the first cycle after rst_n deasserts.
- Reset asserted mid-instruction aborts the instruction immediately. There is no partial RegWrite or PCWrite.
- Minimum latency with zero-wait memory:
  - BR: 3 cycles.
  - R/I/LUI/JAL/JALR: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
- Each wait cycle with ready=0 adds one cycle.
- PCWrite and RegWrite are single-cycle pulses, at most one per instruction.
- imem_ready and dmem_ready are ignored outside FETCH and MEM respectively.
- Opcode is sampled only in DECODE. Changes in other states have no effect.

## Structure
- Package `ctrl_pkg`:
  - opcode localparams;
  - `state_t` enum (FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP);
  - `iclass_t` enum;
  - `trap_cause_t`;
  - ALUOp encodings.
- Sub-module `opcode_decoder`: combinational Opcode → iclass_t, parametrised by ENABLE_JALR. The FSM, wait counter and instret counter live in `multicycle_controller`.

## Test plan
- Zero-wait sequence ADD, ADDI, LUI, LW, SW, BEQ, JAL → latencies 4,4,4,5,4,3,4 cycles; instret=7; ALUOp per class 10,10,11,00,00,01,00.
- LW with dmem_ready low 5 cycles, MEM_TIMEOUT=16 → MemRead and DMemReq held 6 cycles; one RegWrite pulse with MemtoReg=1; no trap.
- imem_ready never asserted, MEM_TIMEOUT=4 → TRAP after 4 wait cycles, trap_cause=10, all enables 0 thereafter; rst_n low → trap clears.
- Opcode 1111111 → TRAP in DECODE, cause 01, no PCWrite; repeat for JALR with ENABLE_JALR=0 → same; with ENABLE_JALR=1 → JalrSel=1 in WRITEBACK.
- rst_n asserted during WRITEBACK of an LW → RegWrite and PCWrite stay 0, instret unchanged at 0; restart at FETCH.
- CNT_W=4, 17 retires → instret=1 (wrap).

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared types for the multi-cycle RISC-V controller: opcodes, FSM states,
// instruction classes, trap causes and ALUOp encodings.
package ctrl_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_RI  = 2'b10;
    localparam logic [1:0] ALUOP_LUI = 2'b11;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP
    } state_t;

    typedef enum logic [3:0] {
        IC_NONE, IC_R, IC_I, IC_LUI, IC_LW, IC_SW, IC_BR, IC_JAL, IC_JALR, IC_ILLEGAL
    } iclass_t;

    typedef enum logic [1:0] {
        TC_NONE    = 2'b00,
        TC_ILLEGAL = 2'b01,
        TC_IMEM    = 2'b10,
        TC_DMEM    = 2'b11
    } trap_cause_t;

    function automatic logic [1:0] alu_op_of(input iclass_t c);
        logic [1:0] op;
        op = ALUOP_ADD;
        case (c)
            IC_R, IC_I: op = ALUOP_RI;
            IC_LUI:     op = ALUOP_LUI;
            IC_BR:      op = ALUOP_BR;
            default:    op = ALUOP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the instruction register/memories and the datapath.
interface multicycle_controller_if #(parameter int CNT_W = 32);
    logic [6:0]       Opcode;
    logic             imem_ready;
    logic             dmem_ready;
    logic             IMemReq;
    logic             DMemReq;
    logic             IRWrite;
    logic             PCWrite;
    logic             ALUSrc;
    logic             MemtoReg;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             Branch;
    logic             JSel;
    logic             JalrSel;
    logic [1:0]       ALUOp;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;

    modport master (
        input  Opcode, imem_ready, dmem_ready,
        output IMemReq, DMemReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
               MemRead, MemWrite, Branch, JSel, JalrSel, ALUOp, trap, trap_cause, instret
    );

    modport slave (
        output Opcode, imem_ready, dmem_ready,
        input  IMemReq, DMemReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
               MemRead, MemWrite, Branch, JSel, JalrSel, ALUOp, trap, trap_cause, instret
    );
endinterface

// File: rtl/multicycle_controller_decoder.sv
// Combinational opcode classifier; anything unrecognised maps to IC_ILLEGAL.
module opcode_decoder
    import ctrl_pkg::*;
#(
    parameter int ENABLE_JALR = 1
) (
    input  logic [6:0] i_opcode,
    output iclass_t    o_class
);

    always_comb begin
        o_class = IC_ILLEGAL;
        case (i_opcode)
            OP_R:    o_class = IC_R;
            OP_I:    o_class = IC_I;
            OP_LUI:  o_class = IC_LUI;
            OP_LW:   o_class = IC_LW;
            OP_SW:   o_class = IC_SW;
            OP_BR:   o_class = IC_BR;
            OP_JAL:  o_class = IC_JAL;
            OP_JALR: o_class = (ENABLE_JALR != 0) ? IC_JALR : IC_ILLEGAL;
            default: o_class = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM with memory-wait timeout, sticky trap and
// retired-instruction counter.
//   state     | meaning
//   FETCH     | request instruction, write IR on imem_ready
//   DECODE    | classify opcode, trap if illegal
//   EXECUTE   | ALU cycle; branches retire here
//   MEM       | data access, wait for dmem_ready; SW retires here
//   WRITEBACK | register write and PC update, retire
//   TRAP      | absorbing fault state, only reset leaves
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int ENABLE_JALR = 1,
    parameter int CNT_W       = 32
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_controller_if.master bus
);

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t            r_state, w_state_next;
    iclass_t           r_class, w_class;
    trap_cause_t       r_cause, w_cause_next;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_instret;

    logic w_ready, w_timeout, w_ex;
    logic w_imem_req, w_dmem_req, w_irwrite, w_pcwrite, w_regwrite;
    logic w_memread, w_memwrite, w_branch;

    opcode_decoder #(.ENABLE_JALR(ENABLE_JALR)) u_dec (
        .i_opcode (bus.Opcode),
        .o_class  (w_class)
    );

    always_comb begin
        w_ready   = (r_state == FETCH) ? bus.imem_ready : bus.dmem_ready;
        // The cycle whose miss would bring the count to the limit is the last one.
        w_timeout = (MEM_TIMEOUT != 0) && !w_ready &&
                    ((32'(r_wait) + 32'd1) == 32'(MEM_TIMEOUT));
    end

    always_comb begin
        w_state_next = r_state;
        w_cause_next = r_cause;
        w_imem_req   = 1'b0;
        w_dmem_req   = 1'b0;
        w_irwrite    = 1'b0;
        w_pcwrite    = 1'b0;
        w_regwrite   = 1'b0;
        w_memread    = 1'b0;
        w_memwrite   = 1'b0;
        w_branch     = 1'b0;
        case (r_state)
            FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_ready) begin
                    w_irwrite    = 1'b1;
                    w_state_next = DECODE;
                end else if (w_timeout) begin
                    w_state_next = TRAP;
                    w_cause_next = TC_IMEM;
                end
            end
            DECODE: begin
                if (w_class == IC_ILLEGAL) begin
                    w_state_next = TRAP;
                    w_cause_next = TC_ILLEGAL;
                end else begin
                    w_state_next = EXECUTE;
                end
            end
            EXECUTE: begin
                case (r_class)
                    IC_BR: begin
                        w_branch     = 1'b1;
                        w_pcwrite    = 1'b1;
                        w_state_next = FETCH;
                    end
                    IC_LW, IC_SW: w_state_next = MEM;
                    default:      w_state_next = WRITEBACK;
                endcase
            end
            MEM: begin
                w_dmem_req = 1'b1;
                w_memread  = (r_class == IC_LW);
                w_memwrite = (r_class == IC_SW);
                if (bus.dmem_ready) begin
                    if (r_class == IC_SW) begin
                        w_pcwrite    = 1'b1;
                        w_state_next = FETCH;
                    end else begin
                        w_state_next = WRITEBACK;
                    end
                end else if (w_timeout) begin
                    w_state_next = TRAP;
                    w_cause_next = TC_DMEM;
                end
            end
            WRITEBACK: begin
                w_regwrite   = 1'b1;
                w_pcwrite    = 1'b1;
                w_state_next = FETCH;
            end
            TRAP:    w_state_next = TRAP;
            default: w_state_next = FETCH;
        endcase
    end

    assign w_ex = (r_state == EXECUTE) || (r_state == MEM) || (r_state == WRITEBACK);

    // Gating with rst_n keeps every strobe low while reset is held, even
    // though the state register already sits in FETCH.
    assign bus.IMemReq    = rst_n & w_imem_req;
    assign bus.DMemReq    = rst_n & w_dmem_req;
    assign bus.IRWrite    = rst_n & w_irwrite;
    assign bus.PCWrite    = rst_n & w_pcwrite;
    assign bus.RegWrite   = rst_n & w_regwrite;
    assign bus.MemRead    = rst_n & w_memread;
    assign bus.MemWrite   = rst_n & w_memwrite;
    assign bus.Branch     = rst_n & w_branch;
    assign bus.ALUSrc     = rst_n & w_ex & ((r_class == IC_LW) || (r_class == IC_SW) ||
                            (r_class == IC_I) || (r_class == IC_LUI) || (r_class == IC_JALR));
    assign bus.MemtoReg   = rst_n & w_ex & (r_class == IC_LW);
    assign bus.JSel       = rst_n & w_ex & (r_class == IC_JAL);
    assign bus.JalrSel    = rst_n & w_ex & (r_class == IC_JALR);
    assign bus.ALUOp      = (rst_n && w_ex) ? alu_op_of(r_class) : ALUOP_ADD;
    assign bus.trap       = rst_n & (r_state == TRAP);
    assign bus.trap_cause = r_cause;
    assign bus.instret    = r_instret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_class   <= IC_NONE;
            r_cause   <= TC_NONE;
            r_wait    <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_state_next;
            r_cause <= w_cause_next;
            if (r_state == DECODE)
                r_class <= w_class;
            if (w_state_next != r_state)
                r_wait <= '0;
            else if (((r_state == FETCH) || (r_state == MEM)) && !w_ready)
                r_wait <= r_wait + 1'b1;
            if (w_pcwrite)
                r_instret <= r_instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: instruction table on a default-parameter controller, plus
// timeout/trap/reset/wrap sequences on a short-timeout, no-JALR, 4-bit-counter one.
module tb_multicycle_controller;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_controller_if #(.CNT_W(32)) ifa ();
    multicycle_controller_if #(.CNT_W(4))  ifb ();

    multicycle_controller #(.MEM_TIMEOUT(16), .ENABLE_JALR(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_a), .bus(ifa));
    multicycle_controller #(.MEM_TIMEOUT(4), .ENABLE_JALR(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_b), .bus(ifb));

    typedef struct {
        logic [6:0] op;
        int dwait;
        int lat;
        int aluop;
        int alusrc;
        int rw;
        int m2r;
        int jsel;
        int jalr;
        int dmem;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int enables_b();
        return int'({ifb.IMemReq, ifb.DMemReq, ifb.IRWrite, ifb.PCWrite, ifb.RegWrite,
                     ifb.MemRead, ifb.MemWrite, ifb.Branch, ifb.ALUSrc, ifb.MemtoReg,
                     ifb.JSel, ifb.JalrSel, ifb.ALUOp});
    endfunction

    // Runs one instruction on dut_a from FETCH until its PCWrite pulse.
    task automatic run_a(input logic [6:0] op, input int dwait,
                         output int lat, output int aluop, output int alusrc,
                         output int rw, output int m2r, output int jsel,
                         output int jalr, output int dmem);
        bit done;
        done = 0; lat = 0; aluop = -1; alusrc = -1;
        rw = 0; m2r = 0; jsel = 0; jalr = 0; dmem = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            ifa.Opcode = op;
            ifa.imem_ready = 1'b1;
            ifa.dmem_ready = 1'b0;
            #1;
            if (ifa.DMemReq) begin
                dmem++;
                if (dmem > dwait) ifa.dmem_ready = 1'b1;
                #1;
            end
            lat++;
            if (ifa.RegWrite) begin
                rw++;
                m2r = int'(ifa.MemtoReg);
            end
            if (ifa.PCWrite) begin
                done   = 1;
                aluop  = int'(ifa.ALUOp);
                alusrc = int'(ifa.ALUSrc);
                jsel   = int'(ifa.JSel);
                jalr   = int'(ifa.JalrSel);
            end
        end
        if (!done) check("retire_budget", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, aluop, alusrc, rw, m2r, jsel, jalr, dmem, cnt, pc, rwc;

        vecs[0] = '{7'b0110011, 0,  4, 2, 0, 1, 0, 0, 0, 0};
        vecs[1] = '{7'b0010011, 0,  4, 2, 1, 1, 0, 0, 0, 0};
        vecs[2] = '{7'b0110111, 0,  4, 3, 1, 1, 0, 0, 0, 0};
        vecs[3] = '{7'b0000011, 0,  5, 0, 1, 1, 1, 0, 0, 1};
        vecs[4] = '{7'b0100011, 0,  4, 0, 1, 0, 0, 0, 0, 1};
        vecs[5] = '{7'b1100011, 0,  3, 1, 0, 0, 0, 0, 0, 0};
        vecs[6] = '{7'b1101111, 0,  4, 0, 0, 1, 0, 1, 0, 0};
        vecs[7] = '{7'b1100111, 0,  4, 0, 1, 1, 0, 0, 1, 0};
        vecs[8] = '{7'b0000011, 5, 10, 0, 1, 1, 1, 0, 0, 6};

        ifa.Opcode = '0; ifa.imem_ready = 1'b1; ifa.dmem_ready = 1'b1;
        ifb.Opcode = '0; ifb.imem_ready = 1'b0; ifb.dmem_ready = 1'b0;

        // Reset state of dut_a, with both ready inputs high
        repeat (3) @(negedge clk);
        #1;
        check("rst_imemreq", int'(ifa.IMemReq), 0);
        check("rst_irwrite", int'(ifa.IRWrite), 0);
        check("rst_instret", int'(ifa.instret), 0);
        check("rst_trap", int'(ifa.trap), 0);
        check("rst_cause", int'(ifa.trap_cause), 0);
        @(negedge clk);
        ifa.imem_ready = 1'b0;
        rst_a = 1'b1;
        #1;
        check("first_imemreq", int'(ifa.IMemReq), 1);

        for (int i = 0; i < 9; i++) begin
            run_a(vecs[i].op, vecs[i].dwait, lat, aluop, alusrc, rw, m2r, jsel, jalr, dmem);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_aluop", i), aluop, vecs[i].aluop);
            check($sformatf("v%0d_alusrc", i), alusrc, vecs[i].alusrc);
            check($sformatf("v%0d_regwrite", i), rw, vecs[i].rw);
            check($sformatf("v%0d_memtoreg", i), m2r, vecs[i].m2r);
            check($sformatf("v%0d_jsel", i), jsel, vecs[i].jsel);
            check($sformatf("v%0d_jalrsel", i), jalr, vecs[i].jalr);
            check($sformatf("v%0d_dmemreq_cycles", i), dmem, vecs[i].dmem);
            check($sformatf("v%0d_trap", i), int'(ifa.trap), 0);
            if (i == 6) begin
                @(posedge clk); #1;
                check("instret_after_7", int'(ifa.instret), 7);
            end
        end
        @(posedge clk); #1;
        check("instret_after_9", int'(ifa.instret), 9);

        // Illegal opcode traps in DECODE without retiring
        pc = 0; rwc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ifa.Opcode = 7'b1111111; ifa.imem_ready = 1'b1; ifa.dmem_ready = 1'b1;
            #1;
            pc += int'(ifa.PCWrite);
            rwc += int'(ifa.RegWrite);
        end
        check("illegal_trap", int'(ifa.trap), 1);
        check("illegal_cause", int'(ifa.trap_cause), 1);
        check("illegal_pcwrite", pc, 0);
        check("illegal_regwrite", rwc, 0);
        check("illegal_imemreq", int'(ifa.IMemReq), 0);
        check("illegal_instret", int'(ifa.instret), 9);
        rst_a = 1'b0;
        #1;
        check("illegal_rst_trap", int'(ifa.trap), 0);
        check("illegal_rst_cause", int'(ifa.trap_cause), 0);

        // Reset during WRITEBACK of an LW
        @(negedge clk);
        ifa.Opcode = 7'b0000011; ifa.imem_ready = 1'b1; ifa.dmem_ready = 1'b1;
        rst_a = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("lw_wb_reached", int'(ifa.RegWrite), 1);
        rst_a = 1'b0;
        #1;
        check("lw_abort_regwrite", int'(ifa.RegWrite), 0);
        check("lw_abort_pcwrite", int'(ifa.PCWrite), 0);
        @(posedge clk); #1;
        check("lw_abort_instret", int'(ifa.instret), 0);
        @(negedge clk);
        ifa.imem_ready = 1'b0;
        rst_a = 1'b1;
        #1;
        check("lw_restart_fetch", int'(ifa.IMemReq), 1);

        // dut_b: instruction memory never ready, MEM_TIMEOUT=4
        @(negedge clk);
        ifb.imem_ready = 1'b0; ifb.Opcode = 7'b0110011;
        rst_b = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            cnt += int'(ifb.IMemReq);
        end
        check("imem_to_wait_cycles", cnt, 4);
        check("imem_to_trap", int'(ifb.trap), 1);
        check("imem_to_cause", int'(ifb.trap_cause), 2);
        ifb.imem_ready = 1'b1; ifb.dmem_ready = 1'b1;
        @(negedge clk); #1;
        check("imem_to_enables", enables_b(), 0);
        check("imem_to_sticky", int'(ifb.trap), 1);
        rst_b = 1'b0;
        #1;
        check("imem_to_rst_trap", int'(ifb.trap), 0);
        check("imem_to_rst_cause", int'(ifb.trap_cause), 0);

        // Ready arriving on the limit cycle wins over the timeout
        @(negedge clk);
        ifb.imem_ready = 1'b0;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        ifb.imem_ready = 1'b1;
        #1;
        check("limit_irwrite", int'(ifb.IRWrite), 1);
        @(negedge clk); #1;
        check("limit_no_trap", int'(ifb.trap), 0);
        check("limit_decode", int'(ifb.IMemReq), 0);
        rst_b = 1'b0;

        // JALR is illegal when disabled
        @(negedge clk);
        ifb.Opcode = 7'b1100111; ifb.imem_ready = 1'b1;
        rst_b = 1'b1;
        pc = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            pc += int'(ifb.PCWrite);
        end
        check("jalr_off_trap", int'(ifb.trap), 1);
        check("jalr_off_cause", int'(ifb.trap_cause), 1);
        check("jalr_off_pcwrite", pc, 0);
        rst_b = 1'b0;

        // 17 branch retires on a 4-bit counter wrap to 1
        @(negedge clk);
        ifb.Opcode = 7'b1100011; ifb.imem_ready = 1'b1;
        rst_b = 1'b1;
        pc = 0;
        for (int c = 0; c < 51; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            pc += int'(ifb.PCWrite);
        end
        @(posedge clk); #1;
        check("wrap_retires", pc, 17);
        check("wrap_instret", int'(ifb.instret), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
